// File: rtl/single_pkg.sv
// Shared single-precision float helpers for the arg-max block and its comparator.
package single_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  localparam logic [7:0] F32_EXP_ALL1 = 8'hFF;
  localparam float32_t   F32_POS_ZERO = 32'h0000_0000;

  function automatic logic f32_is_nan(input float32_t x);
    return (x[30:23] == F32_EXP_ALL1) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic f32_is_zero(input float32_t x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/single_gt.sv
// Combinational strict greater-than for two non-NaN single-precision values.
module single_gt
  import single_pkg::*;
(
  input  float32_t a,
  input  float32_t b,
  output logic     a_gt_b
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves a_gt_b unassigned (no latch).
    a_gt_b = 1'b0;
    if (f32_is_zero(a) && f32_is_zero(b)) begin
      a_gt_b = 1'b0;
    end else if (a[31] != b[31]) begin
      a_gt_b = !a[31];
    end else if (!a[31]) begin
      a_gt_b = a[30:0] > b[30:0];
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_gt_b = a[30:0] < b[30:0];
    end
  end

endmodule

// File: rtl/single_argmax_v.sv
// Sequential arg-max over a captured float32 vector, one element per clock;
// reports index/value of the largest non-NaN element with a one-cycle done pulse.
module single_argmax_v
  import single_pkg::*;
#(
  parameter  int WIDTH = 10,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  float32_t         vector_a [WIDTH],
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] index,
  output float32_t         max_value
);

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  float32_t         r_cap [WIDTH];
  float32_t         r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic             r_best_valid;

  float32_t         w_elem;
  logic             w_elem_gt;
  logic             w_take;
  float32_t         w_nx_best;
  logic [IDX_W-1:0] w_nx_idx;
  logic             w_nx_valid;
  logic             w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_elem   = r_cap[r_cnt];

  single_gt u_gt (
    .a      (w_elem),
    .b      (r_best),
    .a_gt_b (w_elem_gt)
  );

  // Best-so-far including the element under the counter, so the final edge
  // can publish the complete result without an extra cycle.
  assign w_take     = !f32_is_nan(w_elem) && (!r_best_valid || w_elem_gt);
  assign w_nx_best  = w_take ? w_elem : r_best;
  assign w_nx_idx   = w_take ? r_cnt  : r_best_idx;
  assign w_nx_valid = r_best_valid || w_take;

  // NOTE: the capture array is deliberately not reset; it is always written at the accepting edge before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cap <= vector_a;
    end
  end

  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_best       <= F32_POS_ZERO;
      r_best_idx   <= '0;
      r_best_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      index        <= '0;
      max_value    <= F32_POS_ZERO;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt        <= '0;
            r_best_valid <= 1'b0;
            busy         <= 1'b1;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_best       <= w_nx_best;
          r_best_idx   <= w_nx_idx;
          r_best_valid <= w_nx_valid;
          if (r_cnt == CNT_LAST) begin
            max_value <= w_nx_valid ? w_nx_best : r_cap[0];
            index     <= w_nx_valid ? w_nx_idx  : '0;
            found     <= w_nx_valid;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_single_argmax_v.sv
// Self-checking bench for single_argmax_v: vector table, random vectors against a
// reference model, and handshake/reset corner sequences, all scoreboarded.
module tb_single_argmax_v;
  import single_pkg::*;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  typedef logic [WIDTH-1:0][31:0] vec_t;

  typedef struct {
    vec_t             v;
    logic [IDX_W-1:0] idx;
    float32_t         val;
    logic             fnd;
  } vec_rec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    float32_t         val;
    logic             fnd;
    int               acc_cyc;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic             start;
  logic [31:0]      vector_a [WIDTH];
  logic             busy;
  logic             done;
  logic             found;
  logic [IDX_W-1:0] index;
  logic [31:0]      max_value;

  single_argmax_v #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .vector_a  (vector_a),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .index     (index),
    .max_value (max_value)
  );

  exp_t sb [$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   busy_run = 0;
  int   last_busy_run = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input float32_t e0, input float32_t e1,
                              input float32_t e2, input float32_t e3);
    vec_t v;
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    return v;
  endfunction

  // Reference: map each non-NaN value to an order-preserving unsigned key.
  task automatic model(input vec_t v, output logic [IDX_W-1:0] idx,
                       output float32_t val, output logic fnd);
    logic [31:0] x, key, bkey;
    fnd = 1'b0; idx = '0; val = v[0]; bkey = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x = v[i];
      if (x[30:23] == 8'hFF && x[22:0] != 23'd0) continue;
      if (x[30:0] == 31'd0) x = 32'h0;
      key = x[31] ? ~x : (x | 32'h8000_0000);
      if (!fnd || key > bkey) begin
        fnd = 1'b1; bkey = key; idx = IDX_W'(i); val = v[i];
      end
    end
  endtask

  // Call at a negedge with the DUT idle; returns at the next negedge.
  task automatic send(input vec_t v, input logic [IDX_W-1:0] idx,
                      input float32_t val, input logic fnd);
    exp_t e;
    for (int i = 0; i < WIDTH; i++) vector_a[i] = v[i];
    start     = 1'b1;
    e.idx     = idx;
    e.val     = val;
    e.fnd     = fnd;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rstn) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      if (done) begin
        done_count++;
        check("done_single_pulse", prev_done, 0);
        if (sb.size() == 0) begin
          check("done_without_request", done, 0);
        end else begin
          e = sb.pop_front();
          check("index", index, e.idx);
          check("max_value", max_value, e.val);
          check("found", found, e.fnd);
          check("latency", cyc - e.acc_cyc, WIDTH);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 100000", $time);
    $fatal(1);
  end

  vec_rec_t         tbl [8];
  vec_t             rv;
  logic [IDX_W-1:0] m_idx;
  float32_t         m_val;
  logic             m_fnd;
  int               dc;

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) vector_a[i] = '0;

    tbl[0] = '{mk(32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0800000), 2'd1, 32'h40400000, 1'b1};
    tbl[1] = '{mk(32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000), 2'd2, 32'hBF000000, 1'b1};
    tbl[2] = '{mk(32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000), 2'd0, 32'h80000000, 1'b1};
    tbl[3] = '{mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), 2'd0, 32'h40000000, 1'b1};
    tbl[4] = '{mk(32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000), 2'd2, 32'h7F800000, 1'b1};
    tbl[5] = '{mk(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000), 2'd0, 32'h7FC00000, 1'b0};
    tbl[6] = '{mk(32'h00000001, 32'h00000000, 32'h80000001, 32'h007FFFFF), 2'd3, 32'h007FFFFF, 1'b1};
    tbl[7] = '{mk(32'hFFC00001, 32'hC0000000, 32'h7F800001, 32'hBF800000), 2'd3, 32'hBF800000, 1'b1};

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_index", index, 0);
    check("rst_max_value", max_value, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      send(tbl[t].v, tbl[t].idx, tbl[t].val, tbl[t].fnd);
      wait_idle();
    end

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < WIDTH; i++) begin
        rv[i] = $urandom;
        case ($urandom_range(0, 7))
          0: rv[i] = 32'h7F800000 | 32'($urandom_range(1, 32'h7FFFFF)) | {$urandom_range(0, 1), 31'h0};
          1: rv[i] = {$urandom_range(0, 1), 31'h0};
          2: if (i > 0) rv[i] = rv[i-1];
          default: ;
        endcase
      end
      model(rv, m_idx, m_val, m_fnd);
      send(rv, m_idx, m_val, m_fnd);
      wait_idle();
    end

    // Second start two cycles into a scan is ignored.
    dc = done_count;
    send(tbl[0].v, tbl[0].idx, tbl[0].val, tbl[0].fnd);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    check("ignored_start_done_count", done_count, dc + 1);
    check("ignored_start_busy_cycles", last_busy_run, WIDTH);

    // Start coincident with done is accepted.
    dc = done_count;
    send(tbl[1].v, tbl[1].idx, tbl[1].val, tbl[1].fnd);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen_before_b2b", done, 1);
    if (done) send(tbl[4].v, tbl[4].idx, tbl[4].val, tbl[4].fnd);
    wait_idle();
    check("b2b_done_count", done_count, dc + 2);
    check("b2b_busy_cycles", last_busy_run, WIDTH);

    // Operand changes after acceptance do not affect the result.
    send(tbl[0].v, tbl[0].idx, tbl[0].val, tbl[0].fnd);
    for (int i = 0; i < WIDTH; i++) vector_a[i] = 32'h7F800000;
    wait_idle();

    // Reset mid-scan: asynchronous clear, no done, then a clean rerun.
    send(tbl[1].v, tbl[1].idx, tbl[1].val, tbl[1].fnd);
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_found", found, 0);
    check("abort_index", index, 0);
    check("abort_max_value", max_value, 0);
    @(negedge clk);
    rstn = 1'b1;
    dc = done_count;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_count, dc);
    send(tbl[0].v, tbl[0].idx, tbl[0].val, tbl[0].fnd);
    wait_idle();
    check("post_abort_done_count", done_count, dc + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/single_argmax_v.md
# single_argmax_v

Sequential arg-max over a vector of IEEE-754 single-precision values, one element per clock. It sits directly downstream of the vector-plus-scalar adder stage and consumes that stage's `vector_c` and `done` as its `vector_a` and `start`. It returns the index and value of the largest non-NaN element to the classification or output logic of the network.

## Interface
- `WIDTH`, 10, number of vector elements (≥1).
- `IDX_W`, derived and not overridable: `$clog2(WIDTH)`, forced to a minimum of 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; accepted only when idle.
- `vector_a[WIDTH]`  in  32 each  operand vector; sampled only at the accepting edge.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when the result is updated.
- `found`  out  1  at least one non-NaN element existed in the last scan.
- `index`  out  IDX_W  position of the winning element.
- `max_value`  out  32  bit pattern of the winning element.

## Operation
- States:
  - IDLE: accepts `start`.
  - SCAN: element counter `cnt` runs 0..WIDTH-1.
- IDLE, `start`=1 at an edge:
  - copy `vector_a` into an internal WIDTH×32 register;
  - `cnt`←0, `best_valid`←0;
  - → SCAN, `busy`←1.
- SCAN, each edge, element `e` = captured[`cnt`]:
  - if `e` is NaN (exp=0xFF, mantissa≠0): no update;
  - else if `!best_valid` or `e` > `best`: `best`←`e`, `best_idx`←`cnt`, `best_valid`←1;
  - if `cnt`==WIDTH-1, in the same edge:
    - `max_value`←final best (or captured[0] if none valid);
    - `index`←final `best_idx` (0 if none);
    - `found`←final `best_valid`;
    - `done`←1, `busy`←0, → IDLE;
  - else `cnt`←`cnt`+1.
- Greater-than, both operands non-NaN:
  - +0 and −0 compare equal;
  - differing signs: the positive operand is greater;
  - both positive: compare bits[30:0] unsigned, larger wins;
  - both negative: smaller bits[30:0] wins;
  - ±Inf and denormals need no special case.
- Ties: strict greater-than only, so the lowest index wins.
- `start` while in SCAN: ignored. Not queued, no error.
- `vector_a` changes after the accepting edge have no effect on the scan.
- `index`, `max_value` and `found` hold until the next `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `index`=0, `max_value`=0, state=IDLE, `cnt`=0.
- `start` accepted at edge T0 → `busy` high from T0 to T0+WIDTH; `done` high during the cycle following edge T0+WIDTH.
- Latency is exactly WIDTH cycles. For WIDTH=1, `done` follows edge T0+1.
- `done` is a single-cycle pulse and is never high for two consecutive cycles from one request.
- A `start` in the same cycle that `done` is high is accepted, because the state is already IDLE. Back-to-back throughput is one result per WIDTH cycles.
- Upstream `done` feeds `start` directly; no extra register is needed.
- Reset asserted mid-scan: all outputs and state return to reset values immediately. No `done` is produced for the aborted scan.

## Structure
- Shared package `single_pkg`:
  - `float32_t` typedef (logic [31:0]);
  - constants `F32_EXP_ALL1`, `F32_POS_ZERO`;
  - function `f32_is_nan`.
- Sub-module `single_gt`: combinational, inputs `a`, `b`, output `a_gt_b`. Implements the comparison rules above; NaN inputs are don't-care.
- Top level holds the FSM, capture register, counter and best-so-far registers.

## Test plan
- WIDTH=4, vector {3F800000 (1.0), 40400000 (3.0), 40000000 (2.0), C0800000 (−4.0)} → `done` 4 cycles after `start`; `index`=1, `max_value`=40400000, `found`=1.
- All negative {BF800000, C0000000, BF000000, C0400000} → `index`=2, `max_value`=BF000000.
- Ties and zeros:
  - {80000000 (−0), 00000000 (+0), 00000000, 80000000} → `index`=0, `max_value`=80000000;
  - {40000000, 40000000, …} → `index`=0.
- NaN and Inf:
  - {7FC00000 (NaN), FF800000 (−Inf), 7F800000 (+Inf), 7FC00000} → `index`=2, `max_value`=7F800000, `found`=1;
  - all elements 7FC00000 → `index`=0, `max_value`=7FC00000, `found`=0.
- Handshake:
  - second `start` 2 cycles into a scan is ignored: one `done` only, `busy` stays high exactly 4 cycles;
  - `start` coincident with `done` is accepted;
  - changing `vector_a` during the scan leaves the result unchanged.
- Reset: `rstn` pulsed low at scan cycle 2 → outputs zero asynchronously, no `done`. A new `start` after release completes normally with the correct result.
